// File: rtl/score_sequencer_if.sv
// Control/data bundle between the note transcriber, the frame timing source
// and the staff score sequencer.
//   master : drives start/stop/clear pulses, the eighth-note period, detected
//            notes and the frame-start pulse; observes the committed score.
//   slave  : the sequencer; produces notes_out, cursor_out, page_out,
//            running_out and tick_out.
interface score_sequencer_if #(
    parameter int unsigned SLOTS    = 160,
    parameter int unsigned NOTE_W   = 6,
    parameter int unsigned PERIOD_W = 27
);
    logic                           start_in;
    logic                           stop_in;
    logic                           clear_in;
    logic [PERIOD_W-1:0]            eighth_period_in;
    logic                           note_valid_in;
    logic [NOTE_W-1:0]              note_in;
    logic                           new_frame_in;
    logic [SLOTS-1:0][NOTE_W-1:0]   notes_out;
    logic [7:0]                     cursor_out;
    logic [7:0]                     page_out;
    logic                           running_out;
    logic                           tick_out;

    modport master (
        output start_in, stop_in, clear_in, eighth_period_in,
               note_valid_in, note_in, new_frame_in,
        input  notes_out, cursor_out, page_out, running_out, tick_out
    );

    modport slave (
        input  start_in, stop_in, clear_in, eighth_period_in,
               note_valid_in, note_in, new_frame_in,
        output notes_out, cursor_out, page_out, running_out, tick_out
    );
endinterface

// File: rtl/score_sequencer.sv
// Score sequencer: an eighth-note tick timer steps a write cursor through a
// 160-slot page (5 systems x 32 blocks). On each tick the current note (the
// incoming note when valid that cycle, else the held note) is written into a
// staging copy. The staging copy is committed to the renderer-facing array
// only on a frame-start pulse, so a frame never shows a half-updated page.
// Ports:
//   pixel_clk_in : single clock
//   rst_n_in     : asynchronous active-low reset
//   bus (slave)  : start/stop/clear pulses, eighth_period_in, note_valid_in,
//                  note_in, new_frame_in in; notes_out, cursor_out, page_out,
//                  running_out, tick_out out.
// The tick decision is made in the cycle where the slot counter reaches P-1;
// the slot write, cursor/page advance and counter restart happen on that
// clock edge, and tick_out is the registered pulse visible in the following
// cycle together with the updated cursor_out.
module score_sequencer #(
    parameter int unsigned SLOTS    = 160,
    parameter int unsigned NOTE_W   = 6,
    parameter int unsigned PERIOD_W = 27
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    score_sequencer_if.slave  bus
);
    localparam int unsigned CUR_W  = 8;
    localparam int unsigned PAGE_W = 8;
    localparam logic [CUR_W-1:0]    LAST_SLOT  = CUR_W'(SLOTS - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [PERIOD_W-1:0]            cnt_q, cnt_d;
    logic [PERIOD_W-1:0]            period_eff_c;
    logic [CUR_W-1:0]               cursor_q, cursor_d;
    logic [PAGE_W-1:0]              page_q, page_d;
    logic                           dirty_q, dirty_d;
    logic                           tick_q;
    logic                           tick_c;
    logic                           wrap_c;
    logic                           commit_c;
    logic [NOTE_W-1:0]              held_q;
    logic [NOTE_W-1:0]              wr_note_c;
    logic [SLOTS-1:0][NOTE_W-1:0]   staging_q;
    logic [SLOTS-1:0][NOTE_W-1:0]   notes_q;

    // Effective period is clamped to 2; a same-cycle valid note bypasses the holder.
    always_comb begin
        period_eff_c = (bus.eighth_period_in < MIN_PERIOD) ? MIN_PERIOD
                                                           : bus.eighth_period_in;
        wr_note_c    = bus.note_valid_in ? bus.note_in : held_q;
    end

    // Next-state, timer and cursor logic; clear overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        page_d   = page_q;
        dirty_d  = dirty_q;
        tick_c   = 1'b0;
        wrap_c   = 1'b0;
        commit_c = bus.new_frame_in && dirty_q;

        if (commit_c) begin
            dirty_d = 1'b0;
        end

        if (state_q == RUN) begin
            // >= rather than == so a shrinking period cannot overrun the slot.
            if (!bus.clear_in && (cnt_q >= (period_eff_c - PERIOD_W'(1)))) begin
                tick_c = 1'b1;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
            if (bus.stop_in) begin
                state_d = IDLE;
            end
        end else begin
            if (bus.start_in && !bus.stop_in) begin
                state_d = RUN;
            end
        end

        if (tick_c) begin
            cnt_d   = '0;
            dirty_d = 1'b1;
            if (cursor_q == LAST_SLOT) begin
                cursor_d = '0;
                page_d   = page_q + PAGE_W'(1);
                wrap_c   = 1'b1;
            end else begin
                cursor_d = cursor_q + CUR_W'(1);
            end
        end

        if (bus.clear_in) begin
            state_d  = IDLE;
            cnt_d    = '0;
            cursor_d = '0;
            page_d   = '0;
            dirty_d  = 1'b1;
        end
    end

    // State, timer, cursor and flag registers.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cursor_q <= '0;
            page_q   <= '0;
            dirty_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cursor_q <= cursor_d;
            page_q   <= page_d;
            dirty_q  <= dirty_d;
            tick_q   <= tick_c;
        end
    end

    // Held note: last valid note from the transcriber.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            held_q <= '0;
        end else if (bus.note_valid_in) begin
            held_q <= bus.note_in;
        end
    end

    // Staging page; on wrap slots 1..SLOTS-1 are blanked, slot 0 is kept
    // until the next tick overwrites it.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            staging_q <= '0;
        end else if (bus.clear_in) begin
            staging_q <= '0;
        end else if (tick_c) begin
            staging_q[cursor_q] <= wr_note_c;
            if (wrap_c) begin
                for (int unsigned i = 1; i < SLOTS; i++) begin
                    staging_q[i] <= '0;
                end
            end
        end
    end

    // Renderer copy: takes the pre-edge staging contents on a dirty frame start.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            notes_q <= '0;
        end else if (commit_c) begin
            notes_q <= staging_q;
        end
    end

    assign bus.notes_out   = notes_q;
    assign bus.cursor_out  = cursor_q;
    assign bus.page_out    = page_q;
    assign bus.running_out = (state_q == RUN);
    assign bus.tick_out    = tick_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: directed scenarios plus a randomized run, all
// checked against a slot/page/frame reference model kept in the bench.
module tb_score_sequencer;
    localparam int SLOTS = 160;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    score_sequencer_if bus ();

    score_sequencer dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: page contents, shown frame, cursor/page, slot progress.
    int m_stage [SLOTS];
    int m_shown [SLOTS];
    int m_cursor, m_page, m_elapsed, m_held;
    bit m_running, m_dirty, m_tick;

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_stage[i] = 0;
            m_shown[i] = 0;
        end
        m_cursor = 0; m_page = 0; m_elapsed = 0; m_held = 0;
        m_running = 0; m_dirty = 0; m_tick = 0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs now driven.
    task automatic model_edge();
        int p, note;
        bit tick;
        p    = (int'(bus.eighth_period_in) < 2) ? 2 : int'(bus.eighth_period_in);
        note = bus.note_valid_in ? int'(bus.note_in) : m_held;
        // A slot lasts p running cycles; this cycle is the last one of it.
        tick = m_running && !bus.clear_in && (m_elapsed + 1 >= p);
        if (bus.new_frame_in && m_dirty) begin
            m_shown = m_stage;
            m_dirty = 0;
        end
        if (bus.clear_in) begin
            for (int i = 0; i < SLOTS; i++) m_stage[i] = 0;
            m_cursor = 0; m_page = 0; m_elapsed = 0; m_dirty = 1; m_running = 0;
        end else begin
            if (tick) begin
                m_stage[m_cursor] = note;
                m_cursor++;
                if (m_cursor == SLOTS) begin
                    m_cursor = 0;
                    m_page = (m_page + 1) % 256;
                    for (int i = 1; i < SLOTS; i++) m_stage[i] = 0;
                end
                m_elapsed = 0;
                m_dirty = 1;
            end else if (m_running) begin
                m_elapsed++;
            end
            if (bus.stop_in) m_running = 0;
            else if (bus.start_in) m_running = 1;
        end
        if (bus.note_valid_in) m_held = int'(bus.note_in);
        m_tick = tick;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        bus.start_in = 0; bus.stop_in = 0; bus.clear_in = 0; bus.new_frame_in = 0;
    endtask

    task automatic do_clear();
        bus.clear_in = 1;
        step();
    endtask

    task automatic test_reset();
        logic [5:0] nv;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.cursor_out !== 8'd0 || bus.page_out !== 8'd0 || bus.running_out !== 1'b0 || bus.tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_scalars: cursor=%0d page=%0d run=%0b tick=%0b, want all 0", bus.cursor_out, bus.page_out, bus.running_out, bus.tick_out);
        end
        n_checks++;
        if (bus.notes_out !== '0) begin
            n_fail++;
            $display("FAIL reset_notes: notes_out nonzero, want 0");
        end
        rst_n = 1;
        step();
        // Run to cursor 37 while committing every frame, then reset mid-run.
        nv = {1'b1, 5'($urandom)};
        bus.eighth_period_in = 27'd2;
        bus.note_valid_in = 1; bus.note_in = nv;
        bus.start_in = 1;
        step();
        bus.note_valid_in = 0;
        for (int k = 0; k < 300 && m_cursor != 37; k++) begin
            bus.new_frame_in = 1;
            step();
        end
        n_checks++;
        if (bus.cursor_out !== 8'd37 || bus.notes_out[0] !== nv) begin
            n_fail++;
            $display("FAIL reset_prerun: cursor=%0d slot0=%b, want 37 and %b", bus.cursor_out, bus.notes_out[0], nv);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (bus.cursor_out !== 8'd0 || bus.running_out !== 1'b0 || bus.tick_out !== 1'b0 || bus.notes_out !== '0 || bus.page_out !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async: cursor=%0d run=%0b tick=%0b page=%0d, want 0 and notes 0", bus.cursor_out, bus.running_out, bus.tick_out, bus.page_out);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        repeat (3) step();
        n_checks++;
        if (bus.running_out !== 1'b0 || bus.notes_out !== '0 || bus.tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: run=%0b tick=%0b, want IDLE with notes 0", bus.running_out, bus.tick_out);
        end
    endtask

    task automatic test_basic();
        int ticks [8];
        int nt;
        nt = 0;
        bus.eighth_period_in = 27'd10;
        bus.note_valid_in = 1; bus.note_in = 6'b100111;
        bus.start_in = 1;
        step();
        for (int k = 1; k <= 35; k++) begin
            step();
            if (bus.tick_out === 1'b1) begin
                if (nt < 8) ticks[nt] = k;
                nt++;
            end
        end
        n_checks++;
        if (nt != 3 || ticks[0] != 10 || ticks[1] != 20 || ticks[2] != 30) begin
            n_fail++;
            $display("FAIL basic_tick_times: count=%0d first=%0d,%0d,%0d, want 3 at 10,20,30", nt, ticks[0], ticks[1], ticks[2]);
        end
        bus.stop_in = 1;
        step();
        n_checks++;
        if (bus.notes_out !== '0 || bus.cursor_out !== 8'd3) begin
            n_fail++;
            $display("FAIL basic_precommit: cursor=%0d notes nonzero=%0b, want cursor 3 and notes 0", bus.cursor_out, bus.notes_out !== '0);
        end
        bus.new_frame_in = 1;
        step();
        n_checks++;
        if (bus.notes_out[0] !== 6'b100111 || bus.notes_out[1] !== 6'b100111 || bus.notes_out[2] !== 6'b100111 || bus.notes_out[3] !== 6'b000000) begin
            n_fail++;
            $display("FAIL basic_commit: slots0..3=%b %b %b %b, want 100111 x3 then 0", bus.notes_out[0], bus.notes_out[1], bus.notes_out[2], bus.notes_out[3]);
        end
    endtask

    task automatic test_wrap();
        int nt, nz;
        do_clear();
        bus.eighth_period_in = 27'd0;
        bus.note_valid_in = 1;
        bus.start_in = 1;
        nt = 0;
        for (int k = 0; k < 1000 && nt < 160; k++) begin
            bus.note_in = 6'($urandom);
            step();
            if (bus.tick_out === 1'b1) nt++;
        end
        n_checks++;
        if (bus.page_out !== 8'd1 || bus.cursor_out !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_160: page=%0d cursor=%0d, want 1 and 0", bus.page_out, bus.cursor_out);
        end
        bus.note_in = 6'b101001;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.tick_out === 1'b1) break;
        end
        n_checks++;
        if (bus.page_out !== 8'd1 || bus.cursor_out !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_161: page=%0d cursor=%0d, want 1 and 1", bus.page_out, bus.cursor_out);
        end
        bus.stop_in = 1;
        bus.new_frame_in = 1;
        step();
        nz = 0;
        for (int i = 1; i < SLOTS; i++) if (bus.notes_out[i] !== 6'd0) nz++;
        n_checks++;
        if (bus.notes_out[0] !== 6'b101001 || nz != 0) begin
            n_fail++;
            $display("FAIL wrap_commit: slot0=%b nonzero_others=%0d, want 101001 and 0", bus.notes_out[0], nz);
        end
    endtask

    task automatic test_stop_resume();
        int k, nt;
        do_clear();
        bus.note_valid_in = 0;
        bus.eighth_period_in = 27'd10;
        bus.start_in = 1;
        step();
        k = 0;
        do begin step(); k++; end while (bus.tick_out !== 1'b1 && k < 30);
        n_checks++;
        if (k != 10) begin
            n_fail++;
            $display("FAIL stop_first_tick: after %0d cycles, want 10", k);
        end
        repeat (3) step();
        bus.stop_in = 1;
        step();
        nt = 0;
        for (int j = 0; j < 50; j++) begin
            step();
            if (bus.tick_out === 1'b1) nt++;
        end
        n_checks++;
        if (nt != 0 || bus.running_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: ticks=%0d run=%0b, want 0 and 0", nt, bus.running_out);
        end
        bus.start_in = 1;
        step();
        k = 0;
        do begin step(); k++; end while (bus.tick_out !== 1'b1 && k < 30);
        n_checks++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL stop_resume: tick %0d cycles after start, want 6", k);
        end
        bus.stop_in = 1;
        step();
    endtask

    task automatic test_same_cycle();
        logic [5:0] nv;
        int nt;
        nv = {1'b1, 5'($urandom)};
        do_clear();
        bus.eighth_period_in = 27'd4;
        bus.note_valid_in = 1; bus.note_in = nv;
        bus.start_in = 1;
        step();
        nt = 0;
        for (int k = 0; k < 100 && nt < 5; k++) begin
            step();
            if (bus.tick_out === 1'b1) nt++;
        end
        bus.new_frame_in = 1;
        step();
        n_checks++;
        if (bus.notes_out[4] !== nv || bus.notes_out[5] !== 6'd0) begin
            n_fail++;
            $display("FAIL same_pre: slot4=%b slot5=%b, want %b and 0", bus.notes_out[4], bus.notes_out[5], nv);
        end
        step();
        step();
        bus.new_frame_in = 1;
        step();
        n_checks++;
        if (bus.tick_out !== 1'b1 || bus.notes_out[5] !== 6'd0 || bus.cursor_out !== 8'd6) begin
            n_fail++;
            $display("FAIL same_tick_frame: tick=%0b slot5=%b cursor=%0d, want 1, 0, 6", bus.tick_out, bus.notes_out[5], bus.cursor_out);
        end
        bus.new_frame_in = 1;
        step();
        n_checks++;
        if (bus.notes_out[5] !== nv) begin
            n_fail++;
            $display("FAIL same_next_frame: slot5=%b, want %b", bus.notes_out[5], nv);
        end
        step();
        step();
        // This edge would tick; clear with start must suppress it and idle.
        bus.clear_in = 1; bus.start_in = 1;
        step();
        n_checks++;
        if (bus.tick_out !== 1'b0 || bus.running_out !== 1'b0 || bus.cursor_out !== 8'd0 || bus.page_out !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_start: tick=%0b run=%0b cursor=%0d page=%0d, want all 0", bus.tick_out, bus.running_out, bus.cursor_out, bus.page_out);
        end
        bus.new_frame_in = 1;
        step();
        n_checks++;
        if (bus.notes_out !== '0) begin
            n_fail++;
            $display("FAIL clear_commit: slot0=%b slot5=%b, want page all 0", bus.notes_out[0], bus.notes_out[5]);
        end
    endtask

    task automatic test_period_edges();
        int ticks [12];
        int nt, k;
        for (int pv = 0; pv < 2; pv++) begin
            do_clear();
            bus.eighth_period_in = 27'(pv);
            bus.start_in = 1;
            step();
            nt = 0;
            for (int j = 1; j <= 20; j++) begin
                step();
                if (bus.tick_out === 1'b1) begin
                    if (nt < 12) ticks[nt] = j;
                    nt++;
                end
            end
            n_checks++;
            if (nt != 10 || ticks[0] != 2 || ticks[9] != 20) begin
                n_fail++;
                $display("FAIL period_min_%0d: count=%0d first=%0d last=%0d, want 10 at 2..20", pv, nt, ticks[0], ticks[9]);
            end
        end
        do_clear();
        bus.eighth_period_in = 27'd100;
        bus.start_in = 1;
        step();
        nt = 0;
        for (int j = 0; j < 50; j++) begin
            step();
            if (bus.tick_out === 1'b1) nt++;
        end
        bus.eighth_period_in = 27'd5;
        step();
        n_checks++;
        if (nt != 0 || bus.tick_out !== 1'b1) begin
            n_fail++;
            $display("FAIL period_shrink: early_ticks=%0d tick=%0b, want 0 and 1", nt, bus.tick_out);
        end
        k = 0;
        do begin step(); k++; end while (bus.tick_out !== 1'b1 && k < 20);
        n_checks++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL period_after_shrink: interval=%0d, want 5", k);
        end
        bus.stop_in = 1;
        step();
    endtask

    task automatic test_random();
        int bad;
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            bus.start_in     = ($urandom_range(0, 7) == 0);
            bus.stop_in      = ($urandom_range(0, 29) == 0);
            bus.clear_in     = ($urandom_range(0, 599) == 0);
            bus.new_frame_in = ($urandom_range(0, 9) == 0);
            bus.note_valid_in = ($urandom_range(0, 2) == 0);
            bus.note_in      = 6'($urandom);
            if ($urandom_range(0, 15) == 0) bus.eighth_period_in = 27'($urandom_range(0, 6));
            step();
            n_checks++;
            if (bus.tick_out !== m_tick || bus.running_out !== m_running || bus.cursor_out !== 8'(m_cursor) || bus.page_out !== 8'(m_page)) begin
                n_fail++;
                $display("FAIL rand_ctrl cycle %0d: tick=%0b run=%0b cur=%0d page=%0d, want %0b %0b %0d %0d", c, bus.tick_out, bus.running_out, bus.cursor_out, bus.page_out, m_tick, m_running, m_cursor, m_page);
            end
            bad = -1;
            for (int i = SLOTS - 1; i >= 0; i--) if (bus.notes_out[i] !== 6'(m_shown[i])) bad = i;
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL rand_notes cycle %0d: slot %0d = %b, want %b", c, bad, bus.notes_out[bad], 6'(m_shown[bad]));
            end
        end
    endtask

    initial begin
        bus.start_in = 0; bus.stop_in = 0; bus.clear_in = 0; bus.new_frame_in = 0;
        bus.note_valid_in = 0; bus.note_in = '0; bus.eighth_period_in = 27'd10;
        test_reset();
        test_basic();
        test_wrap();
        test_stop_resume();
        test_same_cycle();
        test_period_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
